fmc_mst_if: RTL
===============

// Module: fmc_mst_if
// PURPOSE
//  FMC synchronous PSRAM-mode bus initiator: turns single-beat commands on a
//  valid/ready port into FMC transactions toward an FMC slave (e.g. a
//  BRAM-backed slave port in another FPGA, or the FMC slave in loopback).
//  It drives FMC_CLK, the address, the control strobes and write data, honours
//  FMC_NWAIT, and returns read data and status on a one-cycle response port.
// PARAMETERS
//  C_ADDR_WIDTH      12   FMC_A / cmd_addr width
//  C_DATA_WIDTH      16   data width; multiple of 8
//  C_DATA_LATENCY    2    FMC_CLK rises between the address rise and the data rise (>=1)
//  C_TIMEOUT         255  max consecutive NWAIT-low data rises (FMC_MST_TIMEOUT_EN only)
// PORTS
//  clk        in   1               system clock; FMC_CLK = clk/2 while active
//  rst_n      in   1               async active-low reset
//  cmd_valid  in   1               command request
//  cmd_ready  out  1               command accepted when valid&ready
//  cmd_wr     in   1               1=write, 0=read
//  cmd_addr   in   C_ADDR_WIDTH    word address
//  cmd_wdata  in   C_DATA_WIDTH    write data
//  cmd_be     in   C_DATA_WIDTH/8  write byte enables, active high
//  rsp_valid  out  1               one-clk completion pulse
//  rsp_rdata  out  C_DATA_WIDTH    read data; 0 for writes
//  rsp_err    out  1               timeout abort
//  FMC_CLK    out  1               bus clock, low when idle
//  FMC_A      out  C_ADDR_WIDTH    address
//  FMC_D_O    out  C_DATA_WIDTH    write data
//  FMC_D_T    out  C_DATA_WIDTH    tristate, 1=high-Z
//  FMC_D_I    in   C_DATA_WIDTH    read data
//  FMC_NBL    out  C_DATA_WIDTH/8  byte lanes, active low
//  FMC_NE     out  1               chip enable, active low
//  FMC_NL     out  1               address valid, active low
//  FMC_NOE    out  1               output enable, active low
//  FMC_NWE    out  1               write enable, active low
//  FMC_NWAIT  in   1               slave wait, low=not ready
// BEHAVIOUR
//  - Single clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset values: FMC_CLK=0, FMC_NE/NL/NOE/NWE=1, FMC_NBL all 1, FMC_D_T all 1,
//    FMC_D_O=0, FMC_A=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE.
//  - All FMC outputs are registered; they change only in the clk cycle in which
//    FMC_CLK goes low. FMC_D_I and FMC_NWAIT are sampled at the clk edge that
//    drives FMC_CLK high.
//  - States: IDLE -> ADDR -> LAT -> DATA -> TURN -> IDLE. cmd_ready = (state==IDLE).
//  - IDLE: FMC_CLK held 0. On accept (edge E0), the command is latched and the
//    block enters ADDR. It drives NE=0, NL=0, FMC_A=addr, NWE=~wr, NOE=wr, and
//    NBL=~be for writes or 0 for reads.
//  - ADDR: FMC_CLK=1 at E1 (rise 0, the address rise). At E2 FMC_CLK=0 and NL=1;
//    go to LAT.
//  - LAT: rises 1..C_DATA_LATENCY. For writes, on the fall before the data
//    rise, FMC_D_O=wdata and FMC_D_T=0; go to DATA.
//  - DATA: at rise C_DATA_LATENCY+1 and each later rise, if NWAIT=1 the beat
//    completes (read: capture FMC_D_I). If NWAIT=0 the block holds all outputs
//    and retries at the next rise.
//  - TURN: on the fall after the beat, NE/NOE/NWE=1, NBL all 1, D_T all 1,
//    FMC_CLK stops low, and rsp_valid=1 for one clk. After one more clk the
//    block returns to IDLE, giving a minimum NE-high gap of 2 clk.
//  - Latency: rsp_valid is asserted 2*(C_DATA_LATENCY+2)+2*W clk after the
//    accept edge, where W = NWAIT-low data rises.
//  - A cmd_valid held during a transaction is ignored until IDLE; command
//    inputs are sampled only at accept.
//  - rst_n low mid-transaction: all outputs take reset values immediately, and
//    no response is issued for the aborted command.
// CONFIGURATION
//  FMC_MST_TIMEOUT_EN defined:
//    - A counter of consecutive NWAIT-low data rises is kept.
//    - When it reaches C_TIMEOUT, the block goes to TURN with rsp_err=1 and
//      rsp_rdata=0; a write beat is not counted as done.
//  FMC_MST_TIMEOUT_EN undefined:
//    - The block waits indefinitely; rsp_err is tied 0 and C_TIMEOUT is unused.
// TESTING
//  1 Write addr=0x123 data=0xBEEF be=2'b11, NWAIT=1 -> NL low 1 FMC cycle,
//    D_T=0 on data rise, rsp_valid 8 clk after accept, rsp_err=0.
//  2 Read addr=0x045, slave returns 0x5A5A at rise 3 -> rsp_rdata=0x5A5A,
//    NOE=0 throughout, D_T all 1.
//  3 Write be=2'b01 -> FMC_NBL=2'b10 during NE low.
//  4 Read with NWAIT low for 3 data rises -> rsp_valid at 14 clk, data captured
//    only on NWAIT=1 rise.
//  5 Back-to-back cmd_valid held high -> NE high >=2 clk between transactions,
//    cmd_ready low until IDLE.
//  6 rst_n asserted during LAT -> all outputs at reset values immediately, no
//    rsp_valid; with FMC_MST_TIMEOUT_EN and C_TIMEOUT=4, NWAIT stuck low gives
//    rsp_err=1 after 4 data rises.

Source files
------------

// File: rtl/fmc_mst_if.sv
// FMC synchronous PSRAM-mode initiator: one valid/ready command becomes one FMC beat.
// Optional FMC_MST_TIMEOUT_EN aborts a beat after C_TIMEOUT consecutive NWAIT-low data rises.
module fmc_mst_if #(
   parameter int C_ADDR_WIDTH   = 12,
   parameter int C_DATA_WIDTH   = 16,
   parameter int C_DATA_LATENCY = 2,
   parameter int C_TIMEOUT      = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_wr,
   input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_DATA_WIDTH/8-1:0] cmd_be,
   output logic                      rsp_valid,
   output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                      rsp_err,
   output logic                      FMC_CLK,
   output logic [C_ADDR_WIDTH-1:0]   FMC_A,
   output logic [C_DATA_WIDTH-1:0]   FMC_D_O,
   output logic [C_DATA_WIDTH-1:0]   FMC_D_T,
   input  logic [C_DATA_WIDTH-1:0]   FMC_D_I,
   output logic [C_DATA_WIDTH/8-1:0] FMC_NBL,
   output logic                      FMC_NE,
   output logic                      FMC_NL,
   output logic                      FMC_NOE,
   output logic                      FMC_NWE,
   input  logic                      FMC_NWAIT
);
   localparam int AW = C_ADDR_WIDTH;
   localparam int DW = C_DATA_WIDTH;
   localparam int BW = C_DATA_WIDTH/8;
   localparam int LW = $clog2(C_DATA_LATENCY+1);

   typedef enum logic [2:0] {IDLE, ADDR, LAT, DATA, TURN} state_t;

   typedef struct packed {
      logic          clk_o;
      logic [AW-1:0] a;
      logic [DW-1:0] d_o;
      logic [DW-1:0] d_t;
      logic [BW-1:0] nbl;
      logic          ne;
      logic          nl;
      logic          noe;
      logic          nwe;
   } bus_t;

   localparam bus_t BUS_RST = '{clk_o: 1'b0, a: '0, d_o: '0, d_t: '1, nbl: '1,
                                ne: 1'b1, nl: 1'b1, noe: 1'b1, nwe: 1'b1};

   state_t        state_q, state_d;
   bus_t          bus_q, bus_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] cap_q, cap_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          rsp_valid_d, rsp_err_d;
   logic [DW-1:0] rsp_rdata_d;
   logic          tmo_hit;

   assign cmd_ready = (state_q == IDLE);
   assign FMC_CLK   = bus_q.clk_o;
   assign FMC_A     = bus_q.a;
   assign FMC_D_O   = bus_q.d_o;
   assign FMC_D_T   = bus_q.d_t;
   assign FMC_NBL   = bus_q.nbl;
   assign FMC_NE    = bus_q.ne;
   assign FMC_NL    = bus_q.nl;
   assign FMC_NOE   = bus_q.noe;
   assign FMC_NWE   = bus_q.nwe;

`ifdef FMC_MST_TIMEOUT_EN
   localparam int TW = $clog2(C_TIMEOUT+1);
   logic [TW-1:0] tmo_cnt;

   // tmo_hit flags the low rise that would be the C_TIMEOUT-th in a row
   assign tmo_hit = (tmo_cnt == TW'(C_TIMEOUT-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        tmo_cnt <= '0;
      else if (state_q != DATA)          tmo_cnt <= '0;
      else if (!bus_q.clk_o && !FMC_NWAIT) tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bus_q     <= BUS_RST;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         cap_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         lat_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bus_q     <= bus_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         cap_q     <= cap_d;
         done_q    <= done_d;
         err_q     <= err_d;
         lat_q     <= lat_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

   // Inside a transaction every clk toggles FMC_CLK; bus outputs move only on falls,
   // while beat results (done/err/capture) are taken on rises and acted on at the next fall.
   always_comb begin
      state_d     = state_q;
      bus_d       = bus_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      cap_d       = cap_q;
      done_d      = done_q;
      err_d       = err_q;
      lat_d       = lat_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d   = ADDR;
            bus_d.ne  = 1'b0;
            bus_d.nl  = 1'b0;
            bus_d.a   = cmd_addr;
            bus_d.nwe = ~cmd_wr;
            bus_d.noe = cmd_wr;
            bus_d.nbl = cmd_wr ? ~cmd_be : '0;
            wr_d      = cmd_wr;
            wdata_d   = cmd_wdata;
            cap_d     = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
         end
         ADDR: if (!bus_q.clk_o) begin
            bus_d.clk_o = 1'b1;
         end else begin
            bus_d.clk_o = 1'b0;
            bus_d.nl    = 1'b1;
            lat_d       = '0;
            state_d     = LAT;
         end
         LAT: if (!bus_q.clk_o) begin
            bus_d.clk_o = 1'b1;
            lat_d       = lat_q + 1'b1;
         end else begin
            bus_d.clk_o = 1'b0;
            if (lat_q == LW'(C_DATA_LATENCY)) begin
               state_d = DATA;
               if (wr_q) begin
                  bus_d.d_o = wdata_q;
                  bus_d.d_t = '0;
               end
            end
         end
         DATA: if (!bus_q.clk_o) begin
            bus_d.clk_o = 1'b1;
            if (FMC_NWAIT) begin
               done_d = 1'b1;
               cap_d  = FMC_D_I;
            end else if (tmo_hit) begin
               done_d = 1'b1;
               err_d  = 1'b1;
            end
         end else begin
            bus_d.clk_o = 1'b0;
            if (done_q) begin
               state_d     = TURN;
               bus_d.ne    = 1'b1;
               bus_d.noe   = 1'b1;
               bus_d.nwe   = 1'b1;
               bus_d.nbl   = '1;
               bus_d.d_t   = '1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_rdata_d = (wr_q || err_q) ? '0 : cap_q;
               done_d      = 1'b0;
               err_d       = 1'b0;
            end
         end
         TURN: begin
            state_d     = IDLE;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
